// File: rtl/cpu_run_controller_pkg.sv
// Shared state encodings and address strides for cpu_run_controller and its dump_reader.
// The state codes are plain 3-bit constants so legacy netlists and probes can match them.
package cpu_run_ctrl_pkg;

  typedef logic [2:0] run_state_t;

  localparam run_state_t ST_IDLE     = 3'd0;
  localparam run_state_t ST_LOAD     = 3'd1;
  localparam run_state_t ST_SETTLE   = 3'd2;
  localparam run_state_t ST_RUN      = 3'd3;
  localparam run_state_t ST_DUMP_RD  = 3'd4;
  localparam run_state_t ST_DUMP_WT  = 3'd5;
  localparam run_state_t ST_DUMP_OUT = 3'd6;
  localparam run_state_t ST_DONE     = 3'd7;

  // Byte strides of one imem (32-bit) and one dmem (64-bit) word.
  localparam logic [63:0] IMEM_STRIDE = 64'd4;
  localparam logic [63:0] DMEM_STRIDE = 64'd8;

  localparam int SETTLE_CYC = 1;

endpackage

// File: rtl/cpu_run_controller_if.sv
// Load/dump streams plus the cpu external imem/dmem ports driven by cpu_run_controller.
// master = controller side, slave = environment (source, sink and memories).
interface cpu_run_controller_if;
  logic        ld_valid;
  logic        ld_ready;
  logic        ld_sel;
  logic        ld_last;
  logic [63:0] ld_data;

  logic        dump_valid;
  logic        dump_ready;
  logic [63:0] dump_data;
  logic        dump_last;

  logic [63:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;

  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [63:0] wdata_ext_2;
  logic [63:0] rdata_ext_2;

  modport master (
    input  ld_valid, ld_sel, ld_last, ld_data, dump_ready, rdata_ext_2,
    output ld_ready, dump_valid, dump_data, dump_last,
    output addr_ext, wen_ext, ren_ext, wdata_ext,
    output addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
  );

  modport slave (
    output ld_valid, ld_sel, ld_last, ld_data, dump_ready, rdata_ext_2,
    input  ld_ready, dump_valid, dump_data, dump_last,
    input  addr_ext, wen_ext, ren_ext, wdata_ext,
    input  addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
  );
endinterface

// File: rtl/cpu_run_controller_dump_reader.sv
// dump_reader: DUMP_RD -> DUMP_WT -> DUMP_OUT word sequencing and the dump output register.
// Latency: 3 cycles per word minimum (read, SRAM latency, present).
// Backpressure: word held stable in DUMP_OUT until dump_ready.
module dump_reader
  import cpu_run_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        srst,
  input  run_state_t  state,
  input  logic        enter,
  input  logic [10:0] len,
  input  logic        dump_ready,
  input  logic [63:0] rdata,
  output run_state_t  state_nxt,
  output logic [10:0] idx_nxt,
  output logic        dump_valid,
  output logic [63:0] dump_data,
  output logic        dump_last
);

  logic [10:0] k;
  logic        at_last;

  assign at_last    = (k == len - 11'd1);
  assign dump_valid = (state == ST_DUMP_OUT);
  assign dump_last  = dump_valid & at_last;

  always_comb begin
    state_nxt = state;
    idx_nxt   = enter ? 11'd0 : k;
    case (state)
      ST_DUMP_RD: state_nxt = ST_DUMP_WT;
      ST_DUMP_WT: state_nxt = ST_DUMP_OUT;
      ST_DUMP_OUT: begin
        if (dump_ready) begin
          if (at_last) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_DUMP_RD;
            idx_nxt   = k + 11'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      k         <= '0;
      dump_data <= '0;
    end else begin
      k <= idx_nxt;
      if (state == ST_DUMP_WT) dump_data <= rdata;
    end
  end

endmodule

// File: rtl/cpu_run_controller.sv
// cpu_run_controller: loads imem/dmem, runs the cpu for N cycles, dumps a dmem window.
// Latency: writes appear 1 cycle after load handshake; cpu_enable 2 cycles after last load word.
// Backpressure: ld_ready only in LOAD; dump words wait on dump_ready. CPU_RUN_CTRL_CHECKSUM_EN adds a load checksum.
module cpu_run_controller
  import cpu_run_ctrl_pkg::*;
#(
  parameter int IMEM_DEPTH = 512,
  parameter int DMEM_DEPTH = 1024,
  parameter int CYC_W      = 32
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              start,
  input  logic [CYC_W-1:0]  run_cycles,
  input  logic [10:0]       dump_len,
  cpu_run_controller_if.master bus,
  output logic              cpu_enable,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       checksum
);

  localparam int IPW = $clog2(IMEM_DEPTH + 1);
  localparam int DPW = $clog2(DMEM_DEPTH + 1);
  localparam logic [10:0]      DMEM_LIM    = 11'(DMEM_DEPTH);
  localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYC - 1);

  run_state_t       state, state_nxt, rd_state_nxt;
  logic [IPW-1:0]   i_ptr;
  logic [DPW-1:0]   d_ptr;
  logic [CYC_W-1:0] run_q, cyc_cnt;
  logic [10:0]      len_q, rd_idx_nxt;
  logic             accept, ld_hs, leave, enter_dump;

  assign accept     = start & ((state == ST_IDLE) | (state == ST_DONE));
  assign ld_hs      = bus.ld_valid & bus.ld_ready;
  assign bus.ld_ready = (state == ST_LOAD);
  assign bus.ren_ext  = 1'b0;
  assign cpu_enable = (state == ST_RUN);
  assign busy       = (state != ST_IDLE) & (state != ST_DONE);
  assign done       = (state == ST_DONE);

  always_comb begin
    state_nxt  = state;
    leave      = 1'b0;
    enter_dump = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_LOAD;
      ST_LOAD:          if (ld_hs && bus.ld_last) state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (cyc_cnt == SETTLE_LAST) begin
          if (run_q == '0) leave = 1'b1;
          else             state_nxt = ST_RUN;
        end
      end
      ST_RUN:           if (cyc_cnt == run_q - CYC_W'(1)) leave = 1'b1;
      default:          state_nxt = rd_state_nxt;
    endcase
    // A zero-length dump skips the reader entirely.
    if (leave) begin
      if (len_q == '0) begin
        state_nxt = ST_DONE;
      end else begin
        state_nxt  = ST_DUMP_RD;
        enter_dump = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state           <= ST_IDLE;
      i_ptr           <= '0;
      d_ptr           <= '0;
      run_q           <= '0;
      len_q           <= '0;
      cyc_cnt         <= '0;
      err             <= 1'b0;
      bus.addr_ext    <= '0;
      bus.wen_ext     <= 1'b0;
      bus.wdata_ext   <= '0;
      bus.addr_ext_2  <= '0;
      bus.wen_ext_2   <= 1'b0;
      bus.ren_ext_2   <= 1'b0;
      bus.wdata_ext_2 <= '0;
    end else begin
      state         <= state_nxt;
      bus.wen_ext   <= 1'b0;
      bus.wen_ext_2 <= 1'b0;
      bus.ren_ext_2 <= 1'b0;

      if (state_nxt != state)                        cyc_cnt <= '0;
      else if (state == ST_SETTLE || state == ST_RUN) cyc_cnt <= cyc_cnt + CYC_W'(1);

      if (accept) begin
        i_ptr <= '0;
        d_ptr <= '0;
        err   <= 1'b0;
        run_q <= run_cycles;
        len_q <= (dump_len > DMEM_LIM) ? DMEM_LIM : dump_len;
      end

      // Full pointers saturate: the word is dropped and err sticks.
      if (ld_hs) begin
        if (!bus.ld_sel) begin
          if (i_ptr == IPW'(IMEM_DEPTH)) begin
            err <= 1'b1;
          end else begin
            bus.wen_ext   <= 1'b1;
            bus.addr_ext  <= 64'(i_ptr) * IMEM_STRIDE;
            bus.wdata_ext <= bus.ld_data[31:0];
            i_ptr         <= i_ptr + IPW'(1);
          end
        end else begin
          if (d_ptr == DPW'(DMEM_DEPTH)) begin
            err <= 1'b1;
          end else begin
            bus.wen_ext_2   <= 1'b1;
            bus.addr_ext_2  <= 64'(d_ptr) * DMEM_STRIDE;
            bus.wdata_ext_2 <= bus.ld_data;
            d_ptr           <= d_ptr + DPW'(1);
          end
        end
      end

      if (state_nxt == ST_DUMP_RD) begin
        bus.ren_ext_2  <= 1'b1;
        bus.addr_ext_2 <= 64'(rd_idx_nxt) * DMEM_STRIDE;
      end
    end
  end

  dump_reader u_dump_reader (
    .clk        (clk),
    .srst       (srst),
    .state      (state),
    .enter      (enter_dump),
    .len        (len_q),
    .dump_ready (bus.dump_ready),
    .rdata      (bus.rdata_ext_2),
    .state_nxt  (rd_state_nxt),
    .idx_nxt    (rd_idx_nxt),
    .dump_valid (bus.dump_valid),
    .dump_data  (bus.dump_data),
    .dump_last  (bus.dump_last)
  );

`ifdef CPU_RUN_CTRL_CHECKSUM_EN
  logic [31:0] csum;

  always_ff @(posedge clk) begin
    if (srst)        csum <= '0;
    else if (accept) csum <= '0;
    else if (ld_hs)  csum <= csum + bus.ld_data[31:0] + (bus.ld_sel ? bus.ld_data[63:32] : 32'd0);
  end

  assign checksum = csum;
`else
  assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed self-checking bench for cpu_run_controller (IMEM_DEPTH=4, DMEM_DEPTH=16).
module tb_cpu_run_controller;

  logic        clk = 1'b0;
  logic        srst, start, cpu_enable, busy, done, err;
  logic [31:0] run_cycles, checksum;
  logic [10:0] dump_len;
  int          checks = 0;
  int          errors = 0;

  cpu_run_controller_if bus();

  cpu_run_controller #(.IMEM_DEPTH(4), .DMEM_DEPTH(16), .CYC_W(32)) dut (
    .clk        (clk),
    .srst       (srst),
    .start      (start),
    .run_cycles (run_cycles),
    .dump_len   (dump_len),
    .bus        (bus),
    .cpu_enable (cpu_enable),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  // dmem model with one-cycle read latency
  logic [63:0] mem [16];
  always @(posedge clk) begin
    if (bus.wen_ext_2) mem[bus.addr_ext_2[6:3]] <= bus.wdata_ext_2;
    if (bus.ren_ext_2) bus.rdata_ext_2 <= mem[bus.addr_ext_2[6:3]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] iw_addr[$], dw_addr[$], rd_addr[$], dw_data[$];
  logic [31:0] iw_data[$];
  int en_cnt, en_runs, first_en_cyc, first_rd_cyc, last_hs_cyc;
  logic en_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.wen_ext)   begin iw_addr.push_back(bus.addr_ext); iw_data.push_back(bus.wdata_ext); end
    if (bus.wen_ext_2) begin dw_addr.push_back(bus.addr_ext_2); dw_data.push_back(bus.wdata_ext_2); end
    if (bus.ren_ext_2) begin
      rd_addr.push_back(bus.addr_ext_2);
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
    end
    if (cpu_enable) begin
      en_cnt++;
      if (!en_prev) en_runs++;
      if (first_en_cyc < 0) first_en_cyc = cyc;
    end
    en_prev = cpu_enable;
    if (bus.ld_valid && bus.ld_ready && bus.ld_last) last_hs_cyc = cyc;
  end

  function automatic logic [31:0] cs_exp(input logic [31:0] v);
`ifdef CPU_RUN_CTRL_CHECKSUM_EN
    return v;
`else
    return v & 32'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    iw_addr.delete(); iw_data.delete(); dw_addr.delete(); dw_data.delete(); rd_addr.delete();
    en_cnt = 0; en_runs = 0; first_en_cyc = -1; first_rd_cyc = -1; last_hs_cyc = -1;
  endtask

  task automatic pulse_start(input logic [31:0] rc, input logic [10:0] dl);
    start = 1'b1; run_cycles = rc; dump_len = dl;
    tick();
    start = 1'b0;
  endtask

  task automatic load_word(input logic sel, input logic last, input logic [63:0] d, output bit ok);
    int t = 0;
    bus.ld_valid = 1'b1; bus.ld_sel = sel; bus.ld_last = last; bus.ld_data = d;
    @(negedge clk);
    while (!bus.ld_ready && t < 50) begin @(negedge clk); t++; end
    ok = bus.ld_ready;
    tick();
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
  endtask

  task automatic recv_word(output logic [63:0] d, output logic l, output bit ok);
    int t = 0;
    @(negedge clk);
    while (!bus.dump_valid && t < 100) begin @(negedge clk); t++; end
    ok = bus.dump_valid; d = bus.dump_data; l = bus.dump_last;
    bus.dump_ready = 1'b1;
    tick();
    bus.dump_ready = 1'b0;
  endtask

  localparam logic [63:0] I0 = 64'hDEAD_BEEF_0050_0093;
  localparam logic [63:0] I1 = 64'h1234_5678_00A0_0113;
  localparam logic [63:0] I2 = 64'hFFFF_FFFF_0020_81B3;
  localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] D2 = 64'hCAFE_F00D_1357_9BDF;
  localparam logic [63:0] E0 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] E1 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] G0 = 64'h0BAD_C0DE_600D_F00D;

  task automatic test_reset();
    srst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
    checks++; if (err !== 1'b0 || cpu_enable !== 1'b0) begin errors++; $display("FAIL reset_err_en got %b%b want 00", err, cpu_enable); end
    checks++; if (bus.wen_ext !== 1'b0 || bus.wen_ext_2 !== 1'b0 || bus.ren_ext_2 !== 1'b0 || bus.ren_ext !== 1'b0)
      begin errors++; $display("FAIL reset_mem_en got %b%b%b%b want 0000", bus.wen_ext, bus.wen_ext_2, bus.ren_ext_2, bus.ren_ext); end
    checks++; if (bus.ld_ready !== 1'b0 || bus.dump_valid !== 1'b0 || bus.dump_last !== 1'b0)
      begin errors++; $display("FAIL reset_stream got %b%b%b want 000", bus.ld_ready, bus.dump_valid, bus.dump_last); end
    checks++; if (bus.addr_ext !== 64'd0 || bus.addr_ext_2 !== 64'd0 || bus.dump_data !== 64'd0 || checksum !== 32'd0)
      begin errors++; $display("FAIL reset_data got %h %h %h %h want zeros", bus.addr_ext, bus.addr_ext_2, bus.dump_data, checksum); end
    srst = 1'b0;
    tick();
  endtask

  task automatic test_load_run_dump();
    bit ok, all_ok;
    logic [63:0] got[4]; logic gl[4]; logic [63:0] exp_w[4];
    int t;
    exp_w[0] = D0; exp_w[1] = D1; exp_w[2] = {32'hA5A5_0000, 32'd2}; exp_w[3] = {32'hA5A5_0000, 32'd3};
    clear_logs();
    pulse_start(32'd20, 11'd4);
    all_ok = 1'b1;
    load_word(1'b0, 1'b0, I0, ok); all_ok &= ok;
    load_word(1'b0, 1'b0, I1, ok); all_ok &= ok;
    pulse_start(32'd7, 11'd1); // must be ignored in LOAD
    load_word(1'b0, 1'b0, I2, ok); all_ok &= ok;
    load_word(1'b1, 1'b0, D0, ok); all_ok &= ok;
    load_word(1'b1, 1'b1, D1, ok); all_ok &= ok;
    checks++; if (!all_ok) begin errors++; $display("FAIL load_ready_timeout got 0 want 1"); end

    recv_word(got[0], gl[0], ok);
    checks++; if (!ok) begin errors++; $display("FAIL dump_w0_timeout got 0 want 1"); end
    t = 0;
    @(negedge clk);
    while (!bus.dump_valid && t < 100) begin @(negedge clk); t++; end
    for (int s = 0; s < 5; s++) begin
      checks++; if (bus.dump_valid !== 1'b1 || bus.dump_data !== D1)
        begin errors++; $display("FAIL dump_stall_hold s=%0d got %b %h want 1 %h", s, bus.dump_valid, bus.dump_data, D1); end
      start = (s == 2);
      @(negedge clk);
    end
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL start_in_dump_out got %b%b want 10", busy, done); end
    got[1] = bus.dump_data; gl[1] = bus.dump_last;
    bus.dump_ready = 1'b1; tick(); bus.dump_ready = 1'b0;
    recv_word(got[2], gl[2], ok);
    recv_word(got[3], gl[3], ok);
    checks++; if (!ok) begin errors++; $display("FAIL dump_w3_timeout got 0 want 1"); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (got[i] !== exp_w[i] || gl[i] !== (i == 3))
        begin errors++; $display("FAIL dump_word%0d got %h last=%b want %h last=%b", i, got[i], gl[i], exp_w[i], (i == 3)); end
    end
    @(negedge clk);
    checks++; if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL job1_end got done=%b busy=%b err=%b want 1 0 0", done, busy, err); end

    checks++; if (iw_addr.size() != 3) begin errors++; $display("FAIL imem_wr_count got %0d want 3", iw_addr.size()); end
    else begin
      checks++; if (iw_addr[0] !== 64'h0 || iw_addr[1] !== 64'h4 || iw_addr[2] !== 64'h8)
        begin errors++; $display("FAIL imem_wr_addr got %h %h %h want 0 4 8", iw_addr[0], iw_addr[1], iw_addr[2]); end
      checks++; if (iw_data[0] !== 32'h0050_0093 || iw_data[1] !== 32'h00A0_0113 || iw_data[2] !== 32'h0020_81B3)
        begin errors++; $display("FAIL imem_wr_data got %h %h %h", iw_data[0], iw_data[1], iw_data[2]); end
    end
    checks++; if (dw_addr.size() != 2) begin errors++; $display("FAIL dmem_wr_count got %0d want 2", dw_addr.size()); end
    else begin
      checks++; if (dw_addr[0] !== 64'h0 || dw_addr[1] !== 64'h8 || dw_data[0] !== D0 || dw_data[1] !== D1)
        begin errors++; $display("FAIL dmem_wr got %h:%h %h:%h", dw_addr[0], dw_data[0], dw_addr[1], dw_data[1]); end
    end
    checks++; if (en_cnt != 20 || en_runs != 1) begin errors++; $display("FAIL run20 got cnt=%0d runs=%0d want 20 1", en_cnt, en_runs); end
    checks++; if (first_en_cyc - last_hs_cyc != 2) begin errors++; $display("FAIL en_latency got %0d want 2", first_en_cyc - last_hs_cyc); end
    checks++; if (rd_addr.size() != 4) begin errors++; $display("FAIL rd_count got %0d want 4", rd_addr.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (rd_addr[i] !== 64'(8 * i)) begin errors++; $display("FAIL rd_addr%0d got %h want %h", i, rd_addr[i], 8 * i); end
      end
    end
    checks++; if (checksum !== cs_exp(32'h0050_0093 + 32'h00A0_0113 + 32'h0020_81B3 + 32'h89AB_CDEF + 32'h0123_4567 + 32'h7654_3210 + 32'hFEDC_BA98))
      begin errors++; $display("FAIL checksum_job1 got %h", checksum); end
    tick();
  endtask

  task automatic test_overflow();
    bit ok, all_ok;
    clear_logs();
    pulse_start(32'd3, 11'd0);
    all_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      load_word(1'b0, i == 5, {32'hFFFF_0000, 32'(17 * (i + 1))}, ok);
      all_ok &= ok;
    end
    checks++; if (!all_ok) begin errors++; $display("FAIL ovf_ready_timeout got 0 want 1"); end
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin @(negedge clk); ok = done; end
    checks++; if (!ok) begin errors++; $display("FAIL ovf_done_timeout got 0 want 1"); end
    checks++; if (iw_addr.size() != 4) begin errors++; $display("FAIL ovf_wr_count got %0d want 4", iw_addr.size()); end
    else begin
      checks++; if (iw_addr[3] !== 64'hC || iw_data[3] !== 32'h44) begin errors++; $display("FAIL ovf_wr3 got %h %h want c 44", iw_addr[3], iw_data[3]); end
    end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_err got %b want 1", err); end
    checks++; if (checksum !== cs_exp(32'h0000_0165)) begin errors++; $display("FAIL ovf_checksum got %h", checksum); end
    checks++; if (rd_addr.size() != 0 || en_cnt != 3) begin errors++; $display("FAIL ovf_len0 got rd=%0d en=%0d want 0 3", rd_addr.size(), en_cnt); end
    tick();
  endtask

  task automatic test_run_zero();
    bit ok; logic [63:0] d; logic l;
    clear_logs();
    pulse_start(32'd0, 11'd1);
    @(negedge clk);
    checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL restart_from_done got err=%b busy=%b want 0 1", err, busy); end
    tick();
    load_word(1'b1, 1'b1, D2, ok);
    recv_word(d, l, ok);
    checks++; if (!ok || d !== D2 || l !== 1'b1) begin errors++; $display("FAIL run0_dump got ok=%b %h last=%b want %h 1", ok, d, l, D2); end
    checks++; if (en_cnt != 0) begin errors++; $display("FAIL run0_enable got %0d want 0", en_cnt); end
    checks++; if (first_rd_cyc - last_hs_cyc != 2) begin errors++; $display("FAIL run0_rd_latency got %0d want 2", first_rd_cyc - last_hs_cyc); end
    checks++; if (checksum !== cs_exp(32'h1357_9BDF + 32'hCAFE_F00D)) begin errors++; $display("FAIL run0_checksum got %h", checksum); end
  endtask

  task automatic test_reset_mid_run();
    bit ok, all_ok; logic [63:0] d0, d1; logic l0, l1; int n, t;
    pulse_start(32'd20, 11'd2);
    load_word(1'b1, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, ok);
    n = 0; t = 0;
    while (n < 7 && t < 100) begin @(negedge clk); if (cpu_enable) n++; t++; end
    checks++; if (n != 7) begin errors++; $display("FAIL mid_run_reach got %0d want 7", n); end
    srst = 1'b1;
    @(negedge clk);
    checks++; if (cpu_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL mid_run_reset got en=%b busy=%b done=%b want 000", cpu_enable, busy, done); end
    srst = 1'b0;
    tick();
    clear_logs();
    pulse_start(32'd5, 11'd2);
    all_ok = 1'b1;
    load_word(1'b1, 1'b0, E0, ok); all_ok &= ok;
    load_word(1'b1, 1'b1, E1, ok); all_ok &= ok;
    recv_word(d0, l0, ok); all_ok &= ok;
    recv_word(d1, l1, ok); all_ok &= ok;
    checks++; if (!all_ok || d0 !== E0 || d1 !== E1 || l0 !== 1'b0 || l1 !== 1'b1)
      begin errors++; $display("FAIL post_reset_job got %h/%b %h/%b ok=%b", d0, l0, d1, l1, all_ok); end
    checks++; if (en_cnt != 5 || en_runs != 1) begin errors++; $display("FAIL post_reset_run got %0d/%0d want 5/1", en_cnt, en_runs); end
  endtask

  task automatic test_clamp();
    bit ok, all_ok; logic [63:0] got[16]; logic gl[16]; int nlast;
    clear_logs();
    pulse_start(32'd0, 11'd20);
    load_word(1'b1, 1'b1, G0, ok);
    all_ok = ok; nlast = 0;
    for (int i = 0; i < 16; i++) begin
      recv_word(got[i], gl[i], ok);
      all_ok &= ok;
      if (gl[i]) nlast++;
    end
    checks++; if (!all_ok) begin errors++; $display("FAIL clamp_timeout got 0 want 1"); end
    checks++; if (got[0] !== G0 || got[1] !== E1 || got[2] !== {32'hA5A5_0000, 32'd2})
      begin errors++; $display("FAIL clamp_data got %h %h %h", got[0], got[1], got[2]); end
    checks++; if (nlast != 1 || gl[15] !== 1'b1) begin errors++; $display("FAIL clamp_last got n=%0d l15=%b want 1 1", nlast, gl[15]); end
    @(negedge clk);
    checks++; if (done !== 1'b1 || rd_addr.size() != 16) begin errors++; $display("FAIL clamp_end got done=%b rd=%0d want 1 16", done, rd_addr.size()); end
    else begin
      checks++; if (rd_addr[15] !== 64'h78) begin errors++; $display("FAIL clamp_last_addr got %h want 78", rd_addr[15]); end
    end
  endtask

  initial begin
    srst = 1'b1; start = 1'b0; run_cycles = '0; dump_len = '0;
    bus.ld_valid = 1'b0; bus.ld_sel = 1'b0; bus.ld_last = 1'b0; bus.ld_data = '0; bus.dump_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = {32'hA5A5_0000, 32'(i)};
    clear_logs();
    test_reset();
    test_load_run_dump();
    test_overflow();
    test_run_zero();
    test_reset_mid_run();
    test_clamp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Sequencer that owns the cpu external memory ports and the cpu `enable` input.
- Runs one job in three phases:
  - streams a program image into instruction memory and data memory;
  - runs the core for a programmed number of cycles;
  - streams a window of data memory back out over a valid/ready interface.
- Sits directly above cpu in the test/SoC wrapper and is the sole driver of `addr_ext*`, `wen_ext*`, `ren_ext*`, `wdata_ext*` and `enable`.

Parameters:
- IMEM_DEPTH, 512, instruction memory depth in 32-bit words.
- DMEM_DEPTH, 1024, data memory depth in 64-bit words.
- CYC_W, 32, width of the run-cycle counter.

Ports:
- clk  in  1  clock (shared with cpu).
- srst  in  1  synchronous active-high reset.
- start  in  1  job start pulse; honoured only in IDLE or DONE.
- run_cycles  in  CYC_W  cycles of cpu enable; sampled on accepted start.
- dump_len  in  11  number of dmem words to dump; sampled on accepted start.
- ld_valid / ld_ready  in / out  1 / 1  load stream handshake.
- ld_sel  in  1  0 = instruction word (uses ld_data[31:0]), 1 = data word.
- ld_last  in  1  final load word.
- ld_data  in  64  load payload.
- dump_valid / dump_ready  out / in  1 / 1  dump stream handshake.
- dump_data  out  64  dumped dmem word.
- dump_last  out  1  marks the final dump word.
- cpu_enable  out  1  to cpu enable.
- addr_ext  out  64  instruction memory external port, byte address.
- wen_ext  out  1  instruction memory external write enable.
- ren_ext  out  1  instruction memory external read enable.
- wdata_ext  out  32  instruction memory external write data.
- addr_ext_2  out  64  data memory external port, byte address.
- wen_ext_2  out  1  data memory external write enable.
- ren_ext_2  out  1  data memory external read enable.
- wdata_ext_2  out  64  data memory external write data.
- rdata_ext_2  in  64  data memory external read data.
- busy  out  1  high in any state except IDLE and DONE.
- done  out  1  high in DONE.
- err  out  1  sticky load-overflow flag; cleared on accepted start.
- checksum  out  32  see Optional Feature.

Behaviour:
- Clock and reset: one clock `clk`; reset `srst` is synchronous and active-high.
- Reset value: all outputs 0, state IDLE, `i_ptr`/`d_ptr`/counters 0.
- Reset mid-operation: `srst` mid-job returns the block to IDLE at that edge, drops `cpu_enable` and all `wen`/`ren`; memory contents are left untouched.
- All memory-port outputs are registered. A write is presented in the cycle after its handshake, for exactly one cycle.
- States: IDLE, LOAD, SETTLE, RUN, DUMP_RD, DUMP_WT, DUMP_OUT, DONE.
- IDLE/DONE:
  - `start` moves to LOAD, clears `i_ptr`, `d_ptr`, `err` and the cycle counter, and latches `run_cycles` and `dump_len`.
  - `start` is ignored in every other state.
- LOAD:
  - `ld_ready` = 1; a handshake is `ld_valid & ld_ready`.
  - ld_sel = 0: `addr_ext` = i_ptr×4, `wdata_ext` = ld_data[31:0], `wen_ext` = 1, then i_ptr++.
  - ld_sel = 1: `addr_ext_2` = d_ptr×8, `wdata_ext_2` = ld_data, `wen_ext_2` = 1, then d_ptr++.
  - Overflow: a pointer already at its DEPTH drops the word (no write) and sets `err`; the pointer saturates.
  - A handshake with `ld_last` goes to SETTLE.
- SETTLE: one cycle so the final write lands before the core fetches; then RUN, or straight to DUMP_RD if the latched run_cycles = 0.
- RUN:
  - `cpu_enable` = 1 for exactly the latched run_cycles cycles; then DUMP_RD.
  - No `wen`/`ren` asserted during RUN.
- DUMP (latched dump_len = 0 skips to DONE):
  - DUMP_RD: `ren_ext_2` = 1, `addr_ext_2` = k×8.
  - DUMP_WT: captures `rdata_ext_2` into the `dump_data` register (1-cycle SRAM read latency).
  - DUMP_OUT: `dump_valid` = 1 and held with data stable until `dump_ready`.
  - `dump_last` = 1 when k = dump_len−1.
  - Throughput is 1 word per 3 cycles minimum.
  - dump_len > DMEM_DEPTH is clamped to DMEM_DEPTH.
- Simultaneous events: `ld_valid` outside LOAD is ignored; `dump_ready` outside DUMP_OUT is ignored.

Optional Feature:
- Macro `CPU_RUN_CTRL_CHECKSUM_EN`.
- Defined: `checksum` accumulates a 32-bit wrapping sum of the low and high 32-bit halves of every accepted load word (instruction words contribute ld_data[31:0] only, including dropped overflow words). It is cleared on accepted start and held stable afterwards.
- Undefined: `checksum` is tied to 0 and the accumulator logic is absent.

Decomposition:
- Package `cpu_run_ctrl_pkg`: the state enum, the byte-stride constants 4 and 8, and the SETTLE length constant.
- One sub-module, `dump_reader`, containing the DUMP_RD/DUMP_WT/DUMP_OUT sequencing plus the output holding register. Everything else stays in the top FSM.

Test Plan:
- Load 3 imem words (0x00500093, 0x00A00113, 0x002081B3) and 2 dmem words, ld_last on the 5th → wen_ext pulses at addr 0x0/0x4/0x8, wen_ext_2 pulses at addr 0x0/0x8, cpu_enable first high 2 cycles after the last handshake.
- run_cycles = 20 → cpu_enable high exactly 20 consecutive cycles; run_cycles = 0 → cpu_enable never high, DUMP_RD follows SETTLE.
- dump_len = 4 with dump_ready stalled 5 cycles on word 1 → dump_data constant while stalled, words 0..3 from addr 0x0..0x18 in order, dump_last only on word 3, then done = 1.
- IMEM_DEPTH = 4, send 6 imem words → 4 writes only, err = 1, checksum (if enabled) still covers all 6 words.
- srst asserted in RUN cycle 7 → cpu_enable = 0 and state IDLE the next cycle; a new start performs a full job correctly.
- start pulsed during LOAD and DUMP_OUT → no effect; start in DONE → new job with err cleared.
